// File: rtl/seven_segment_scanner.sv
// Multiplexed seven-segment scanner: double-buffered hex value with leading-zero blanking.
// Each digit slot starts with one blank cycle; the display buffer only updates at frame boundaries.
module seven_segment_scanner #(
  parameter int unsigned w_digit      = 6,
  parameter int unsigned dwell_cycles = 50000,
  parameter int unsigned blank_zeros  = 1
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [4*w_digit-1:0] i_number,
  input  logic [w_digit-1:0]   i_dots,
  input  logic                 i_in_valid,
  output logic [7:0]           o_abcdefgh,
  output logic [w_digit-1:0]   o_digit,
  output logic                 o_frame_done
);

  localparam int unsigned IdxW = $clog2(w_digit);
  localparam int unsigned CntW = $clog2(dwell_cycles);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(w_digit - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(dwell_cycles - 1);

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] seg;
    unique case (nib)
      4'h0: seg = 8'hFC;
      4'h1: seg = 8'h60;
      4'h2: seg = 8'hDA;
      4'h3: seg = 8'hF2;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'hB6;
      4'h6: seg = 8'hBE;
      4'h7: seg = 8'hE0;
      4'h8: seg = 8'hFE;
      4'h9: seg = 8'hF6;
      4'hA: seg = 8'hEE;
      4'hB: seg = 8'h3E;
      4'hC: seg = 8'h9C;
      4'hD: seg = 8'h7A;
      4'hE: seg = 8'h9E;
      4'hF: seg = 8'h8E;
      default: seg = 8'h00;
    endcase
    return seg;
  endfunction

  logic [4*w_digit-1:0] r_shadow_num;
  logic [w_digit-1:0]   r_shadow_dots;
  logic [4*w_digit-1:0] r_disp_num;
  logic [w_digit-1:0]   r_disp_dots;
  logic [IdxW-1:0]      r_idx;
  logic [CntW-1:0]      r_cnt;
  logic [7:0]           r_abcdefgh;
  logic [w_digit-1:0]   r_digit;
  logic                 r_frame_done;

  logic                 w_cnt_wrap;
  logic                 w_frame_end;
  logic [CntW-1:0]      w_cnt_d;
  logic [IdxW-1:0]      w_idx_d;
  logic [w_digit-1:0]   w_zero_above;
  logic [w_digit-1:0]   w_onehot;
  logic [3:0]           w_nib;
  logic                 w_dot;
  logic                 w_suppress;
  logic [7:0]           w_enc;
  logic [7:0]           w_seg_d;

  always_comb begin
    w_cnt_wrap  = (r_cnt == CntLast);
    w_frame_end = w_cnt_wrap && (r_idx == IdxLast);
    w_cnt_d     = w_cnt_wrap ? '0 : r_cnt + CntW'(1);
    if (!w_cnt_wrap) begin
      w_idx_d = r_idx;
    end else if (r_idx == IdxLast) begin
      w_idx_d = '0;
    end else begin
      w_idx_d = r_idx + IdxW'(1);
    end
  end

  // Bit i set when nibble i and every more-significant nibble are zero.
  always_comb begin
    w_zero_above = '0;
    for (int i = 0; i < w_digit; i++) begin
      w_zero_above[i] = ~|(r_disp_num >> (4 * i));
    end
  end

  always_comb begin
    w_nib      = '0;
    w_dot      = 1'b0;
    w_onehot   = '0;
    w_suppress = 1'b0;
    for (int i = 0; i < w_digit; i++) begin
      if (r_idx == IdxW'(i)) begin
        w_nib       = r_disp_num[4*i +: 4];
        w_dot       = r_disp_dots[i];
        w_onehot[i] = 1'b1;
        w_suppress  = (blank_zeros != 0) && (i != 0) && w_zero_above[i];
      end
    end
    w_enc   = seg_encode(w_nib);
    // The dot follows its request even on a suppressed digit.
    w_seg_d = w_suppress ? {7'b0, w_dot} : {w_enc[7:1], w_dot};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadow_num  <= '0;
      r_shadow_dots <= '0;
      r_disp_num    <= '0;
      r_disp_dots   <= '0;
      r_idx         <= '0;
      r_cnt         <= '0;
      r_abcdefgh    <= '0;
      r_digit       <= '0;
      r_frame_done  <= 1'b0;
    end else begin
      r_cnt <= w_cnt_d;
      r_idx <= w_idx_d;
      if (i_in_valid) begin
        r_shadow_num  <= i_number;
        r_shadow_dots <= i_dots;
      end
      // A strobe in the boundary cycle bypasses the shadow so it is not lost for a frame.
      if (w_frame_end) begin
        r_disp_num  <= i_in_valid ? i_number : r_shadow_num;
        r_disp_dots <= i_in_valid ? i_dots : r_shadow_dots;
      end
      r_frame_done <= w_frame_end;
      if (r_cnt == '0) begin
        r_digit    <= '0;
        r_abcdefgh <= '0;
      end else begin
        r_digit    <= w_onehot;
        r_abcdefgh <= w_seg_d;
      end
    end
  end

  assign o_abcdefgh   = r_abcdefgh;
  assign o_digit      = r_digit;
  assign o_frame_done = r_frame_done;

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 The module SHALL have parameter w_digit, default 6, giving the number of multiplexed digits (legal range 2..8).
REQ-002 The module SHALL have parameter dwell_cycles, default 50000, giving the clk cycles per digit slot, blank cycle included (legal range ≥ 2).
REQ-003 The module SHALL have parameter blank_zeros, default 1, which enables leading-zero suppression when set to 1.
REQ-004 clk  input  1  single clock; all flops rise on posedge clk.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 number  input  4*w_digit  hex value; nibble i drives digit i, where digit 0 is the least significant.
REQ-007 dots  input  w_digit  decimal-point request per digit.
REQ-008 in_valid  input  1  one-cycle strobe that captures number/dots into the shadow register.
REQ-009 abcdefgh  output  8  active-high segments; bit 7 = a, ..., bit 1 = g, bit 0 = h (dot).
REQ-010 digit  output  w_digit  active-high one-hot digit enable, or all zero when blank.
REQ-011 frame_done  output  1  one-cycle pulse at every frame boundary.

Function
REQ-012 The block SHALL hold three registers: shadow {number, dots}, display {number, dots}, and a scan state {idx, cnt}.
- idx counts 0..w_digit-1.
- cnt counts 0..dwell_cycles-1.
REQ-013 On any in_valid=1 cycle, the shadow register SHALL load number/dots; the last strobe before a frame boundary wins.
REQ-014 cnt SHALL increment every cycle and wrap to 0 after dwell_cycles-1; on that wrap, idx SHALL advance, wrapping from w_digit-1 to 0.
REQ-015 Slot phases:
- cnt==0 is BLANK: digit and abcdefgh SHALL both be registered to all zeros.
- cnt≥1 is SHOW: digit SHALL be registered as one-hot of idx, and abcdefgh as the encoding of display digit idx.
REQ-016 Frame boundary = the cycle in which idx wraps w_digit-1→0.
- On that clock edge, display SHALL load from shadow and frame_done SHALL register 1 for exactly one cycle.
- If in_valid=1 in the boundary cycle, display SHALL load the incoming number/dots directly (bypass), and shadow SHALL load them as well.
REQ-017 Outputs SHALL be registered with exactly one cycle of latency from the scan state; no combinational path from number/dots/in_valid to any output.
REQ-018 Nibble encoding (bits a..g, h=0): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6, A=EE, b=3E, C=9C, d=7A, E=9E, F=8E (hex).
REQ-019 abcdefgh bit 0 SHALL equal the display dots bit for the shown digit, independent of blanking.
REQ-020 When blank_zeros=1, digit i>0 SHALL show segments a..g = 0 if every display nibble j≥i is zero.
- digit still asserts during suppression.
- Digit 0 is never suppressed.
REQ-021 When blank_zeros=0, every nibble SHALL be encoded per REQ-018.
REQ-022 Display/shadow updates SHALL never change abcdefgh in the middle of a frame (no tearing).

Reset
REQ-023 While rst_n=0, the block SHALL hold:
- shadow=0, display=0, idx=0, cnt=0;
- digit=0, abcdefgh=0, frame_done=0.
REQ-024 After rst_n deasserts, the first cycle SHALL be BLANK for idx 0.
- If rst_n deasserts on the clk edge, the reset-state outputs persist through that cycle.
- One cycle later, the block SHALL show digit 0 = FC with digit=…0001.
REQ-025 Reset asserted mid-slot or mid-frame SHALL immediately (asynchronously) clear outputs and discard pending shadow data.

Verification (w_digit=4, dwell_cycles=4, blank_zeros=1 unless stated)
REQ-026 Reset release, no input -> per 4-cycle slot the outputs SHALL be: blank; digit=0001/abcdefgh=FC for 3 cycles; then digits 0010/0100/1000 with abcdefgh=00; frame_done pulses once every 16 cycles.
REQ-027 in_valid mid-frame with number=16'h12A5, dots=0 -> the current frame is unchanged; the next frame SHALL show B6, EE, DA, 60 on digits 0..3; nothing is suppressed.
REQ-028 number=16'h0030, dots=4'b1000 -> digit0 FC, digit1 F2, digit2 00 (suppressed), digit3 01 (dot only); with blank_zeros=0, digit2=FC and digit3=FD.
REQ-029 in_valid strobed in the boundary cycle with 16'hFFFF, plus an earlier strobe of 16'h1111 -> the frame starting next SHALL show 8E on all digits.
REQ-030 rst_n pulsed low during a SHOW cycle of digit 2 with a loaded value -> outputs clear the same cycle; after release, the scan restarts at digit 0 showing FC with nibbles 1..3 suppressed.
